// File: rtl/cu_state_fsm_if.sv
// Control-unit bundle: FSM inputs (en, mem_ready, ns) and every decoded datapath control.
// slave = the cu_state_fsm side, master = the surrounding control unit / environment.
interface cu_state_fsm_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic             mem_ready;
  logic [3:0]       ns;
  logic [3:0]       state;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_state;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport slave (
    input  en, mem_ready, ns,
    output state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           illegal_state, cycle_count, instr_count
  );

  modport master (
    output en, mem_ready, ns,
    input  state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           illegal_state, cycle_count, instr_count
  );
endinterface

// File: rtl/cu_state_fsm.sv
// Multicycle control unit: state register plus Moore decode of datapath controls.
// Define CU_PERF_CNT_EN to add the cycle / completed-fetch performance counters.
module cu_state_fsm #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  cu_state_fsm_if.slave      bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BEQ      = 4'd8,
    S_JUMP     = 4'd9
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   mem_wait;
  logic   adv;
  logic   strobe_en;

  // Memory states only leave once the access completes.
  assign mem_wait  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign adv       = bus.en && (!mem_wait || bus.mem_ready);
  // Strobes must stay quiet while reset is held, even mid-cycle.
  assign strobe_en = adv && rst_n;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    if (adv) begin
      if (bus.ns < 4'd10) begin
        state_d = state_e'(bus.ns);
      end else begin
        state_d   = S_FETCH;
        illegal_d = 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments with async active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.ir_write  = strobe_en;
        bus.pc_write  = strobe_en;
        bus.alu_src_b = 2'b01;
      end
      S_DECODE:  bus.alu_src_b = 2'b11;
      S_MEMADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_LW_WB: begin
        bus.reg_write  = strobe_en;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_R_WB: begin
        bus.reg_write = strobe_en;
        bus.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = strobe_en;
        bus.pc_source     = 2'b01;
      end
      S_JUMP: begin
        bus.pc_write  = strobe_en;
        bus.pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.state         = state_q;
  assign bus.illegal_state = illegal_q;

`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (adv && (state_q == S_FETCH)) begin
        instr_q <= instr_q + 1'b1;
      end
    end
  end

  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;
`else
  assign bus.cycle_count = {CNT_W{1'b0}};
  assign bus.instr_count = {CNT_W{1'b0}};
`endif

endmodule
